// File: rtl/tl45_fetch.sv
// tl45 instruction fetch stage: PC, pipelined Wishbone read master, fetch->decode buffer.
// Optional macro TL45_FETCH_ALIGN_CHECK_EN traps misaligned redirect targets.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_new_pc,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [2:0] {
    S_RESTART,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pend_pc, pend_pc_d;
  logic [31:0] pend_inst, pend_inst_d;
  logic [31:0] buf_pc_d, buf_inst_d;
  logic        err_d;
  logic        cyc_d, stb_d;
  logic [29:0] addr_d;
  logic [31:0] redirect_pc;

  assign pc_plus4 = pc + 32'd4;

`ifdef TL45_FETCH_ALIGN_CHECK_EN
  assign redirect_pc = i_new_pc;
`else
  logic unused_new_pc_lsbs;
  assign unused_new_pc_lsbs = ^i_new_pc[1:0];
  assign redirect_pc = {i_new_pc[31:2], 2'b00};
`endif

  // Next-state and next-output logic; flush outranks stall, ack and err.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    pend_pc_d   = pend_pc;
    pend_inst_d = pend_inst;
    err_d       = o_fetch_err;
    cyc_d       = o_wb_cyc;
    stb_d       = o_wb_stb;
    addr_d      = o_wb_addr;
    buf_pc_d    = i_pipe_stall ? o_buf_pc   : 32'd0;
    buf_inst_d  = i_pipe_stall ? o_buf_inst : 32'd0;

    if (i_pipe_flush) begin
      buf_pc_d    = 32'd0;
      buf_inst_d  = 32'd0;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      pend_pc_d   = 32'd0;
      pend_inst_d = 32'd0;
      pc_d        = redirect_pc;
      state_d     = S_RESTART;
`ifdef TL45_FETCH_ALIGN_CHECK_EN
      if (i_new_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end
`endif
    end else begin
      case (state)
        S_RESTART: begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          addr_d  = pc[31:2];
          state_d = S_REQ;
        end
        // REQ first raises the strobe if a previous cycle just ended, then waits for acceptance.
        S_REQ: begin
          if (!o_wb_stb) begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            addr_d = pc[31:2];
          end else if (!i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_wb_err) begin
            err_d   = 1'b1;
            cyc_d   = 1'b0;
            state_d = S_HALT;
          end else if (i_wb_ack) begin
            cyc_d = 1'b0;
            if (!i_pipe_stall) begin
              buf_pc_d   = pc;
              buf_inst_d = i_wb_data;
              pc_d       = pc_plus4;
              state_d    = S_REQ;
            end else begin
              pend_pc_d   = pc;
              pend_inst_d = i_wb_data;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!i_pipe_stall) begin
            buf_pc_d   = pend_pc;
            buf_inst_d = pend_inst;
            pc_d       = pc_plus4;
            state_d    = S_REQ;
          end
        end
        S_HALT: begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
        default: state_d = S_RESTART;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_RESTART;
      pc          <= RESET_PC;
      pend_pc     <= 32'd0;
      pend_inst   <= 32'd0;
      o_buf_pc    <= 32'd0;
      o_buf_inst  <= 32'd0;
      o_fetch_err <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_addr   <= 30'd0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pend_pc     <= pend_pc_d;
      pend_inst   <= pend_inst_d;
      o_buf_pc    <= buf_pc_d;
      o_buf_inst  <= buf_inst_d;
      o_fetch_err <= err_d;
      o_wb_cyc    <= cyc_d;
      o_wb_stb    <= stb_d;
      o_wb_addr   <= addr_d;
    end
  end

endmodule

// File: tb/tb_tl45_fetch.sv
// Self-checking bench for tl45_fetch: Wishbone slave model, decode-side scoreboard,
// vector table plus hand sequences for flush, error and stall corners.
module tb_tl45_fetch;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pipe_stall = 1'b0;
  logic        i_pipe_flush = 1'b0;
  logic [31:0] i_new_pc = 32'd0;
  logic [31:0] o_buf_pc;
  logic [31:0] o_buf_inst;
  logic        o_fetch_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [29:0] o_wb_addr;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_stall = 1'b0;
  logic        i_wb_err = 1'b0;
  logic [31:0] i_wb_data = 32'd0;

  int checks = 0;
  int errors = 0;
  int ack_delay = 1;
  bit err_mode = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] new_pc;
    int          wb_stall_cycles;
    int          pipe_stall_cycles;
    logic [29:0] exp_addr;
    logic [31:0] exp_pc;
    logic [29:0] exp_next_addr;
  } vec_t;
  vec_t vecs[4];

  tl45_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_pipe_stall(i_pipe_stall),
    .i_pipe_flush(i_pipe_flush),
    .i_new_pc    (i_new_pc),
    .o_buf_pc    (o_buf_pc),
    .o_buf_inst  (o_buf_inst),
    .o_fetch_err (o_fetch_err),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_addr   (o_wb_addr),
    .i_wb_ack    (i_wb_ack),
    .i_wb_stall  (i_wb_stall),
    .i_wb_err    (i_wb_err),
    .i_wb_data   (i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] data_for(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hA500_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Slave: accepts any strobe not stalled, answers ack_delay cycles later with ack or err.
  initial begin : slave
    logic        acc;
    logic [29:0] addr_q;
    int          cnt;
    acc = 1'b0;
    addr_q = '0;
    cnt = 0;
    forever begin
      @(negedge i_clk);
      acc = o_wb_cyc && o_wb_stb && !i_wb_stall;
      if (acc) addr_q = o_wb_addr;
      @(posedge i_clk);
      #1;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      i_wb_data = 32'd0;
      if (acc) cnt = ack_delay;
      if (cnt == 1) begin
        if (err_mode) i_wb_err = 1'b1;
        else begin
          i_wb_ack = 1'b1;
          i_wb_data = data_for(addr_q);
        end
      end
      if (cnt > 0) cnt--;
    end
  end

  // Decode-side monitor: every buffer update must be a clear, a hold, a bubble or the oldest accepted fetch.
  initial begin : monitor
    logic        prev_stall, prev_clear, acc;
    logic [31:0] last_pc, last_inst;
    exp_t        e;
    prev_stall = 1'b0;
    prev_clear = 1'b1;
    last_pc = 32'd0;
    last_inst = 32'd0;
    forever begin
      @(negedge i_clk);
      if (prev_clear) begin
        checkOutput("sb_clear_pc", o_buf_pc, 32'd0);
        checkOutput("sb_clear_inst", o_buf_inst, 32'd0);
      end else if (prev_stall) begin
        checkOutput("sb_hold_pc", o_buf_pc, last_pc);
        checkOutput("sb_hold_inst", o_buf_inst, last_inst);
      end else if (o_buf_inst != 32'd0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected actual=%h expected=bubble", o_buf_inst);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_pc", o_buf_pc, e.pc);
          checkOutput("sb_inst", o_buf_inst, e.inst);
        end
      end else begin
        checkOutput("sb_bubble_pc", o_buf_pc, 32'd0);
      end
      last_pc = o_buf_pc;
      last_inst = o_buf_inst;
      acc = o_wb_cyc && o_wb_stb && !i_wb_stall;
      if (i_reset || i_pipe_flush) sb.delete();
      else begin
        if (i_wb_err && sb.size() > 0) void'(sb.pop_front());
        if (acc) sb.push_back('{pc: {o_wb_addr, 2'b00}, inst: data_for(o_wb_addr)});
      end
      prev_stall = i_pipe_stall;
      prev_clear = i_reset || i_pipe_flush;
    end
  end

  // Redirect, optionally stall the bus and decode, then check request, delivery and the next request.
  task automatic applyStimulus(input vec_t v);
    i_pipe_flush = 1'b1;
    i_new_pc = v.new_pc;
    step();
    checkOutput("vec_flush_buf_pc", o_buf_pc, 32'd0);
    checkOutput("vec_flush_cyc", 32'(o_wb_cyc), 32'd0);
    i_pipe_flush = 1'b0;
    i_wb_stall = (v.wb_stall_cycles > 0);
    step();
    for (int c = 1; c <= v.wb_stall_cycles + 1; c++) begin
      if (c > 1) step();
      i_wb_stall = (c <= v.wb_stall_cycles);
      if (c == v.wb_stall_cycles + 1) i_pipe_stall = (v.pipe_stall_cycles > 0);
      checkOutput("vec_stb", 32'(o_wb_stb), 32'd1);
      checkOutput("vec_addr", 32'(o_wb_addr), 32'(v.exp_addr));
    end
    step();
    checkOutput("vec_wait_cyc", 32'(o_wb_cyc), 32'd1);
    checkOutput("vec_wait_stb", 32'(o_wb_stb), 32'd0);
    step();
    if (v.pipe_stall_cycles > 0) begin
      for (int h = 2; h < v.pipe_stall_cycles; h++) begin
        checkOutput("vec_hold_inst", o_buf_inst, 32'd0);
        checkOutput("vec_hold_cyc", 32'(o_wb_cyc), 32'd0);
        step();
      end
      checkOutput("vec_hold_stb", 32'(o_wb_stb), 32'd0);
      checkOutput("vec_hold_cyc", 32'(o_wb_cyc), 32'd0);
      i_pipe_stall = 1'b0;
      step();
    end
    checkOutput("vec_buf_pc", o_buf_pc, v.exp_pc);
    checkOutput("vec_buf_inst", o_buf_inst, data_for(v.exp_addr));
    step();
    checkOutput("vec_bubble_inst", o_buf_inst, 32'd0);
    checkOutput("vec_next_stb", 32'(o_wb_stb), 32'd1);
    checkOutput("vec_next_addr", 32'(o_wb_addr), 32'(v.exp_next_addr));
  endtask

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vecs[0] = '{32'h0000_2000, 0, 0, 30'h0000_0800, 32'h0000_2000, 30'h0000_0801};
    vecs[1] = '{32'h0000_0100, 3, 0, 30'h0000_0040, 32'h0000_0100, 30'h0000_0041};
    vecs[2] = '{32'h0000_3000, 0, 5, 30'h0000_0C00, 32'h0000_3000, 30'h0000_0C01};
    vecs[3] = '{32'hFFFF_FFFC, 2, 2, 30'h3FFF_FFFF, 32'hFFFF_FFFC, 30'h0000_0000};

    // Reset state and first fetch from RESET_PC.
    step();
    step();
    checkOutput("rst_cyc", 32'(o_wb_cyc), 32'd0);
    checkOutput("rst_stb", 32'(o_wb_stb), 32'd0);
    checkOutput("rst_addr", 32'(o_wb_addr), 32'd0);
    checkOutput("rst_buf_pc", o_buf_pc, 32'd0);
    checkOutput("rst_buf_inst", o_buf_inst, 32'd0);
    checkOutput("rst_err", 32'(o_fetch_err), 32'd0);
    i_reset = 1'b0;
    step();
    checkOutput("a_stb", 32'(o_wb_stb), 32'd1);
    checkOutput("a_addr", 32'(o_wb_addr), 32'h40);
    step();
    checkOutput("a_wait_stb", 32'(o_wb_stb), 32'd0);
    step();
    checkOutput("a_buf_pc", o_buf_pc, 32'h100);
    checkOutput("a_buf_inst", o_buf_inst, data_for(30'h40));
    checkOutput("a_cyc_drop", 32'(o_wb_cyc), 32'd0);
    step();
    checkOutput("a_bubble", o_buf_inst, 32'd0);
    checkOutput("a_next_addr", 32'(o_wb_addr), 32'h41);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Flush while a read is outstanding; the late ack must be dropped.
    ack_delay = 2;
    i_pipe_flush = 1'b1;
    i_new_pc = 32'h300;
    step();
    i_pipe_flush = 1'b0;
    step();
    checkOutput("b_addr", 32'(o_wb_addr), 32'hC0);
    step();
    checkOutput("b_wait_cyc", 32'(o_wb_cyc), 32'd1);
    i_pipe_flush = 1'b1;
    i_new_pc = 32'h2000;
    step();
    checkOutput("b_flush_cyc", 32'(o_wb_cyc), 32'd0);
    checkOutput("b_flush_buf", o_buf_inst, 32'd0);
    i_pipe_flush = 1'b0;
    step();
    checkOutput("b_restart_stb", 32'(o_wb_stb), 32'd1);
    checkOutput("b_restart_addr", 32'(o_wb_addr), 32'h800);
    checkOutput("b_late_ack_ignored", o_buf_inst, 32'd0);
    step();
    step();
    checkOutput("b_slow_wait_cyc", 32'(o_wb_cyc), 32'd1);
    step();
    checkOutput("b_buf_pc", o_buf_pc, 32'h2000);
    checkOutput("b_buf_inst", o_buf_inst, data_for(30'h800));
    ack_delay = 1;

    // Bus error halts fetch until a redirect; the error flag is sticky.
    i_pipe_flush = 1'b1;
    i_new_pc = 32'h500;
    step();
    i_pipe_flush = 1'b0;
    step();
    checkOutput("c_addr", 32'(o_wb_addr), 32'h140);
    err_mode = 1'b1;
    step();
    step();
    err_mode = 1'b0;
    checkOutput("c_err", 32'(o_fetch_err), 32'd1);
    checkOutput("c_err_cyc", 32'(o_wb_cyc), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("c_halt_cyc", 32'(o_wb_cyc), 32'd0);
      checkOutput("c_halt_inst", o_buf_inst, 32'd0);
    end
    i_pipe_flush = 1'b1;
    i_new_pc = 32'h40;
    step();
    i_pipe_flush = 1'b0;
    step();
    checkOutput("c_resume_addr", 32'(o_wb_addr), 32'h10);
    checkOutput("c_resume_stb", 32'(o_wb_stb), 32'd1);
    step();
    step();
    checkOutput("c_resume_pc", o_buf_pc, 32'h40);
    checkOutput("c_err_sticky", 32'(o_fetch_err), 32'd1);

    // Reset clears the error; then flush arrives together with a decode stall.
    i_reset = 1'b1;
    step();
    checkOutput("d_rst_err", 32'(o_fetch_err), 32'd0);
    i_reset = 1'b0;
    i_pipe_flush = 1'b1;
    i_new_pc = 32'h600;
    step();
    i_pipe_flush = 1'b0;
    step();
    checkOutput("d_addr", 32'(o_wb_addr), 32'h180);
    step();
    step();
    checkOutput("d_buf_pc", o_buf_pc, 32'h600);
    i_pipe_stall = 1'b1;
    step();
    checkOutput("d_held_pc", o_buf_pc, 32'h600);
    checkOutput("d_held_inst", o_buf_inst, data_for(30'h180));
    i_pipe_flush = 1'b1;
    i_new_pc = 32'h700;
    step();
    checkOutput("d_flush_pc", o_buf_pc, 32'd0);
    checkOutput("d_flush_inst", o_buf_inst, 32'd0);
    checkOutput("d_flush_cyc", 32'(o_wb_cyc), 32'd0);
    i_pipe_flush = 1'b0;
    step();
    checkOutput("d_new_addr", 32'(o_wb_addr), 32'h1C0);
    i_pipe_stall = 1'b0;

    // Misaligned redirect target.
    i_pipe_flush = 1'b1;
    i_new_pc = 32'h2002;
    step();
    i_pipe_flush = 1'b0;
    checkOutput("e_flush_cyc", 32'(o_wb_cyc), 32'd0);
`ifdef TL45_FETCH_ALIGN_CHECK_EN
    checkOutput("e_align_err", 32'(o_fetch_err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("e_halt_cyc", 32'(o_wb_cyc), 32'd0);
      checkOutput("e_halt_stb", 32'(o_wb_stb), 32'd0);
    end
`else
    checkOutput("e_no_err", 32'(o_fetch_err), 32'd0);
    step();
    checkOutput("e_addr", 32'(o_wb_addr), 32'h800);
    step();
    step();
    checkOutput("e_buf_pc", o_buf_pc, 32'h2000);
    checkOutput("e_buf_inst", o_buf_inst, data_for(30'h800));
`endif

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
